h264_dc_transform: RTL and testbench
====================================

Name: h264_dc_transform

Overview:
- 2x2 forward Hadamard DC transform for H.264 chroma DC coefficients.
- Takes four 16-bit DC samples serially and produces four 16-bit transformed coefficients serially.
- Sits between the 4x4 core-transform DC extraction and the chroma DC quantiser.
- Double-buffered: an input collector plus an output buffer, so a new block can stream in while the previous block drains.

Parameters:
- TOGETHER, 0: 0 = output words emitted one per cycle while READYO is high; 1 = once started, all four output words are emitted in 4 consecutive cycles regardless of READYO.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- READYI  out  1  high when the collector can accept an input word.
- ENABLE  in  1  XXIN holds a valid input word this cycle.
- XXIN  in  16  signed input DC sample.
- VALID  out  1  YYOUT holds an output word this cycle; downstream must take it.
- YYOUT  out  16  signed transformed coefficient.
- READYO  in  1  downstream can take a word.

Interface: one clock; reset is synchronous and active-high (CLK, RESET).

Behaviour:
- Reset: VALID=0, YYOUT=0, READYI=1; collector count=0; output buffer empty; no pending block. Reset mid-block discards all partial and buffered data.
- Input:
  - Word captured at posedge when ENABLE=1 and READYI=1.
  - Words x0,x1,x2,x3 in 2x2 raster order (c00,c01,c10,c11).
  - ENABLE may drop between words; the count is retained.
  - ENABLE while READYI=0: word ignored.
- Transform, computed when the 4th word is captured:
  - y0=x0+x1+x2+x3
  - y1=x0-x1+x2-x3
  - y2=x0+x1-x2-x3
  - y3=x0-x1-x2+x3
  - 18-bit internal arithmetic; result truncated to the low 16 bits (two's-complement wrap) unless the optional feature is on.
- Transfer to the output buffer:
  - Happens at the edge after the 4th capture, if the output buffer is empty or its last word is being emitted that edge. The collector then resets to count 0.
  - Otherwise the block is pending; READYI=0 (combinational: READYI = !pending) until the transfer happens.
- Output, TOGETHER=0:
  - At each posedge where the buffer is non-empty and READYO=1: VALID<=1, YYOUT<=next word, in order y0,y1,y2,y3.
  - Otherwise VALID<=0, YYOUT<=0.
- Output, TOGETHER=1:
  - Burst starts at a posedge where the buffer is full and READYO=1.
  - VALID=1 for exactly 4 consecutive cycles with y0..y3.
  - READYO is ignored during the burst.
- Latency: 4th input captured at edge N → buffer loaded at N+1 → y0 with VALID at N+2 (if READYO high).
- Simultaneous events: a collector fill coinciding with emission of the last word of the previous block transfers without a stall. Back-to-back blocks with READYO held high never deassert READYI.
- Outputs VALID/YYOUT are registered.

Optional Feature:
- Macro H264DC_SATURATE_EN.
- Defined: each output clamps the 18-bit sum to [-32768, 32767].
- Undefined: modulo-2^16 wrap.
- Handshake and latency are identical in both cases.

Decomposition:
- Package h264dc_pkg:
  - typedef coef_t (logic signed [15:0]);
  - typedef acc_t (signed [17:0]);
  - localparam BLK_WORDS=4;
  - function hadamard2x2 (4 coef_t in → 4 acc_t out).
- One natural sub-module: h264dc_hadamard_core, the combinational butterfly plus optional saturation.
- Collector, output buffer and sequencing stay in the top.

Test Plan:
- Block 1,2,3,4 with READYO=1 → VALID burst 000A, FFFE, FFFC, 0000; y0 two edges after the 4th input edge.
- Block 1,2,3,4, ENABLE low one cycle, then 5,6,7,8 with READYO=1 → outputs 000A,FFFE,FFFC,0000 then 001A,FFFE,FFFC,0000; READYI stays 1 throughout.
- TOGETHER=0, READYO toggling 1,0,1,0… on block 7FFF,7FFF,7FFF,7FFF → VALID only on READYO-high cycles; y0=FFFC (wrap) or 7FFF with H264DC_SATURATE_EN.
- READYO=0 held while two blocks enter → second block pends, READYI=0 after its 4th word, extra ENABLE words ignored; raising READYO drains block 1, then block 2, and READYI returns to 1.
- TOGETHER=1, READYO pulsed high one cycle with buffer full → 4 consecutive VALID cycles with all four words.
- RESET asserted after 2 input words → VALID=0, YYOUT=0, READYI=1; the next 4 words form a fresh block with correct results.

Source files
------------

// File: rtl/h264dc_pkg.sv
// Shared types and the 2x2 Hadamard butterfly for the chroma DC transform.
package h264dc_pkg;

  typedef logic signed [15:0] coef_t;
  typedef logic signed [17:0] acc_t;

  localparam int BLK_WORDS = 4;

  typedef coef_t [BLK_WORDS-1:0] coef_blk_t;
  typedef acc_t  [BLK_WORDS-1:0] acc_blk_t;

  // Full-precision butterfly: 18 bits hold 4 * (-32768) without overflow.
  function automatic acc_blk_t hadamard2x2(input coef_blk_t x);
    acc_t a0, a1, a2, a3;
    acc_t s0, s1, d0, d1;
    acc_blk_t y;
    a0 = $signed(x[0]);
    a1 = $signed(x[1]);
    a2 = $signed(x[2]);
    a3 = $signed(x[3]);
    s0 = a0 + a1;
    d0 = a0 - a1;
    s1 = a2 + a3;
    d1 = a2 - a3;
    y[0] = s0 + s1;
    y[1] = d0 + d1;
    y[2] = s0 - s1;
    y[3] = d0 - d1;
    return y;
  endfunction

endpackage

// File: rtl/h264dc_hadamard_core.sv
// Combinational 2x2 Hadamard core; H264DC_SATURATE_EN clamps each result to
// the 16-bit signed range, otherwise results wrap modulo 2^16.
module h264dc_hadamard_core
  import h264dc_pkg::*;
(
  input  coef_blk_t x,
  output coef_blk_t y
);

  acc_blk_t sum;

  assign sum = hadamard2x2(x);

  generate
    for (genvar gi = 0; gi < BLK_WORDS; gi++) begin : g_out
`ifdef H264DC_SATURATE_EN
      acc_t s;
      assign s = $signed(sum[gi]);
      assign y[gi] = (s > 18'sd32767)  ? 16'sh7fff :
                     (s < -18'sd32768) ? 16'sh8000 : coef_t'(s);
`else
      assign y[gi] = coef_t'(sum[gi]);
`endif
    end
  endgenerate

endmodule

// File: rtl/h264_dc_transform.sv
// Serial-in / serial-out 2x2 chroma DC Hadamard transform with a collector
// and an output buffer. Optional clamping via H264DC_SATURATE_EN.
module h264_dc_transform
  import h264dc_pkg::*;
#(
  parameter int TOGETHER = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        READYI,
  input  logic        ENABLE,
  input  logic [15:0] XXIN,
  output logic        VALID,
  output logic [15:0] YYOUT,
  input  logic        READYO
);

  coef_blk_t  col_reg;
  logic [1:0] col_cnt_reg;
  logic       col_full_reg;

  coef_blk_t  buf_reg;
  logic [1:0] rd_idx_reg;
  logic       buf_busy_reg;

  coef_blk_t  core_y;
  logic       capture;
  logic       emit;
  logic       emit_last;
  logic       load;

  h264dc_hadamard_core u_core (
    .x (col_reg),
    .y (core_y)
  );

  // In burst mode a started block (index past y0) keeps draining without READYO.
  assign emit      = buf_busy_reg && (READYO || (TOGETHER != 0 && rd_idx_reg != 2'd0));
  assign emit_last = emit && (rd_idx_reg == 2'd3);
  assign load      = col_full_reg && (!buf_busy_reg || emit_last);
  assign READYI    = !col_full_reg || load;
  assign capture   = ENABLE && READYI;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      col_reg      <= '0;
      col_cnt_reg  <= 2'd0;
      col_full_reg <= 1'b0;
    end else begin
      if (capture) begin
        col_reg[col_cnt_reg] <= coef_t'(XXIN);
        col_cnt_reg          <= col_cnt_reg + 2'd1;
      end
      // A full collector being unloaded can already take the next block's x0.
      if (capture && col_cnt_reg == 2'd3) begin
        col_full_reg <= 1'b1;
      end else if (load) begin
        col_full_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_reg      <= '0;
      rd_idx_reg   <= 2'd0;
      buf_busy_reg <= 1'b0;
      VALID        <= 1'b0;
      YYOUT        <= 16'd0;
    end else begin
      VALID <= emit;
      YYOUT <= emit ? buf_reg[rd_idx_reg] : 16'd0;
      if (emit) begin
        rd_idx_reg <= rd_idx_reg + 2'd1;
      end
      if (load) begin
        buf_reg      <= core_y;
        buf_busy_reg <= 1'b1;
        rd_idx_reg   <= 2'd0;
      end else if (emit_last) begin
        buf_busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_h264_dc_transform.sv
// Randomised and directed bench for h264_dc_transform; both TOGETHER settings
// run side by side against a block-level arithmetic reference model.
module tb_h264_dc_transform;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        readyo;
  logic [15:0] xxin;
  logic        readyi [2];
  logic        valid  [2];
  logic [15:0] yyout  [2];

  always #5 clk = ~clk;

  h264_dc_transform #(.TOGETHER(0)) u_dut0 (
    .CLK(clk), .RESET(rst), .READYI(readyi[0]), .ENABLE(enable),
    .XXIN(xxin), .VALID(valid[0]), .YYOUT(yyout[0]), .READYO(readyo)
  );

  h264_dc_transform #(.TOGETHER(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .READYI(readyi[1]), .ENABLE(enable),
    .XXIN(xxin), .VALID(valid[1]), .YYOUT(yyout[1]), .READYO(readyo)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          col_q [2][$];
  logic [15:0] exp_q [2][$];
  int          burst_pos [2];
  int          vcount [2];
  int          readyi_expect = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fit(input int v);
    int c;
    c = v;
`ifdef H264DC_SATURATE_EN
    if (c > 32767) c = 32767;
    else if (c < -32768) c = -32768;
`endif
    return c[15:0];
  endfunction

  // Reference: collect four words, then queue the four Hadamard outputs.
  function automatic void model_word(input int d, input logic [15:0] w);
    int x [4];
    col_q[d].push_back(int'($signed(w)));
    if (col_q[d].size() == 4) begin
      for (int i = 0; i < 4; i++) x[i] = col_q[d][i];
      col_q[d].delete();
      exp_q[d].push_back(fit(x[0] + x[1] + x[2] + x[3]));
      exp_q[d].push_back(fit(x[0] - x[1] + x[2] - x[3]));
      exp_q[d].push_back(fit(x[0] + x[1] - x[2] - x[3]));
      exp_q[d].push_back(fit(x[0] - x[1] - x[2] + x[3]));
    end
  endfunction

  task automatic observe(input int k, input logic ro);
    logic [15:0] e;
    if (valid[k]) begin
      vcount[k]++;
      check($sformatf("exp_available%0d", k), exp_q[k].size() != 0, 1'b1);
      if (exp_q[k].size() != 0) begin
        e = exp_q[k].pop_front();
        check($sformatf("yyout%0d", k), yyout[k], e);
      end
      if (k == 0) begin
        check("valid_gate0", ro, 1'b1);
      end else begin
        if (burst_pos[1] == 0) check("burst_start1", ro, 1'b1);
        burst_pos[1] = (burst_pos[1] + 1) % 4;
      end
    end else begin
      check($sformatf("idle_zero%0d", k), yyout[k], 16'h0000);
      if (k == 1) check("burst_gap1", burst_pos[1], 0);
    end
  endtask

  task automatic cycle(input logic en, input logic [15:0] d, input logic ro);
    logic acc [2];
    enable = en;
    xxin   = d;
    readyo = ro;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      acc[k] = en && readyi[k];
      if (readyi_expect >= 0)
        check($sformatf("readyi%0d", k), readyi[k], readyi_expect[0]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) model_word(k, d);
      observe(k, ro);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    readyo = 1'b0;
    xxin   = 16'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      col_q[k].delete();
      exp_q[k].delete();
      burst_pos[k] = 0;
      check($sformatf("rst_valid%0d", k), valid[k], 1'b0);
      check($sformatf("rst_yyout%0d", k), yyout[k], 16'h0000);
      check($sformatf("rst_readyi%0d", k), readyi[k], 1'b1);
    end
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 2; k++)
      check($sformatf("%s_empty%0d", tag, k), exp_q[k].size(), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; readyo = 1'b0; xxin = 16'h0;
    do_reset();

    // Single block, latency of two edges from the 4th capture to y0.
    for (int w = 1; w <= 4; w++) cycle(1'b1, 16'(w), 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 2; k++) check($sformatf("lat_n1_%0d", k), valid[k], 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 2; k++) check($sformatf("lat_n2_%0d", k), valid[k], 1'b1);
    drain(6, "t1");

    // Two blocks with a one-cycle ENABLE gap; READYI never drops.
    readyi_expect = 1;
    for (int w = 1; w <= 4; w++) cycle(1'b1, 16'(w), 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    for (int w = 5; w <= 8; w++) cycle(1'b1, 16'(w), 1'b1);
    drain(8, "t2");
    readyi_expect = -1;

    // Overflowing block with READYO toggling.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h7fff, 1'(i % 2 == 0));
    for (int i = 0; i < 12; i++) cycle(1'b0, 16'h0, 1'(i % 2 == 0));
    for (int k = 0; k < 2; k++) check($sformatf("t3_empty%0d", k), exp_q[k].size(), 0);

    // Back-pressure: second block pends, extra words refused.
    readyi_expect = 1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'($urandom), 1'b0);
    readyi_expect = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0);
    readyi_expect = -1;
    for (int i = 0; i < 12; i++) cycle(1'b0, 16'h0, 1'b1);
    readyi_expect = 1;
    drain(1, "t4");
    readyi_expect = -1;

    // One-cycle READYO pulse with a full buffer.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    vcount[0] = 0;
    vcount[1] = 0;
    cycle(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'b0);
    check("pulse_words0", vcount[0], 1);
    check("pulse_words1", vcount[1], 4);
    drain(6, "t5");

    // Reset in the middle of a block.
    cycle(1'b1, 16'h1234, 1'b1);
    cycle(1'b1, 16'h5678, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 1'b1);
    drain(7, "t6");

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    drain(16, "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
